// File: rtl/mnist_frame_loader.sv
// Pixel-stream front end for the forward_pass engine: binarizes a 28x28 frame,
// then sequences the engine through clear, start and a wait for done.
`timescale 1ns/1ps

module mnist_frame_loader #(
   parameter int         NUM_PIXELS = 784,
   parameter logic [7:0] THRESHOLD  = 8'd128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   input  logic        pix_last,
   output logic        pix_ready,
   output logic        image_data [0:NUM_PIXELS-1],
   output logic        nn_rst,
   output logic        nn_start,
   input  logic        nn_done,
   output logic        frame_done,
   output logic        frame_err,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam logic [9:0] LAST_IDX = 10'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {
      S_FILL,
      S_DRAIN,
      S_CLEAR,
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [9:0] idx;
   logic       wait_armed;
   logic       beat;
   logic       at_last;
   logic       nn_rst_next;
   logic       nn_start_next;
   logic       frame_done_next;
   logic       frame_err_next;

   // Ready is held low while reset is asserted even though the state is already FILL.
   assign pix_ready = !rst && ((state == S_FILL) || (state == S_DRAIN));
   assign busy      = (state != S_FILL);
   assign beat      = pix_valid && pix_ready;
   assign at_last   = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FILL;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      nn_rst_next     = 1'b0;
      nn_start_next   = 1'b0;
      frame_done_next = 1'b0;
      frame_err_next  = 1'b0;
      case (state)
         S_FILL: begin
            if (beat) begin
               if (at_last && pix_last) begin
                  state_next  = S_CLEAR;
                  nn_rst_next = 1'b1;
               end else if (at_last) begin
                  state_next     = S_DRAIN;
                  frame_err_next = 1'b1;
               end else if (pix_last) begin
                  frame_err_next = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (beat && pix_last) begin
               state_next = S_FILL;
            end
         end
         S_CLEAR: begin
            state_next    = S_LAUNCH;
            nn_start_next = 1'b1;
         end
         S_LAUNCH: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            // wait_armed masks a done left over from the previous frame
            if (wait_armed && nn_done) begin
               state_next      = S_FILL;
               frame_done_next = 1'b1;
            end
         end
         default: begin
            state_next = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nn_rst     <= 1'b0;
         nn_start   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= 16'd0;
         wait_armed <= 1'b0;
      end else begin
         nn_rst     <= nn_rst_next;
         nn_start   <= nn_start_next;
         frame_done <= frame_done_next;
         frame_err  <= frame_err_next;
         wait_armed <= (state == S_WAIT);
         if (frame_done_next) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   // Short frames leave stale bits behind; the next frame overwrites them from index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= 10'd0;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            image_data[i] <= 1'b0;
         end
      end else if ((state == S_FILL) && beat) begin
         image_data[idx] <= (pix_data >= THRESHOLD);
         if (at_last || pix_last) begin
            idx <= 10'd0;
         end else begin
            idx <= idx + 10'd1;
         end
      end
   end

endmodule
